hazard_ctrl: RTL and testbench

Pipeline interlock controller for the five-stage RV32 core. It keeps a per-register scoreboard of in-flight destination writes, covering instructions issued from DE and not yet retired by WB. It stalls DE on RAW hazards and serializes control-flow instructions until AGEX resolves them. Its outputs drive the DE stall path toward FE and the bubble insertion into the DE latch.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sb_counter_array.sv | 57 +++++
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the DE-stage interlock controller.
package hazard_pkg;

    localparam int NREGS     = 32;
    localparam int REGNOBITS = 5;
    localparam int CNTBITS   = 2;

    function automatic int cnt_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNTBITS);

    typedef enum logic {
        HZ_RUN       = 1'b0,
        HZ_CTRL_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/sb_counter_array.sv
// Per-register saturating pending-write counters with WB-bypassed busy view.
module sb_counter_array #(
    parameter int NREGS     = hazard_pkg::NREGS,
    parameter int REGNOBITS = hazard_pkg::REGNOBITS,
    parameter int CNTBITS   = hazard_pkg::CNTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic [REGNOBITS-1:0] inc_idx,
    input  logic                 dec,
    input  logic [REGNOBITS-1:0] dec_idx,
    output logic [NREGS-1:0]     busy_mask,
    output logic                 overflow,
    output logic                 underflow
);
    import hazard_pkg::*;

    localparam logic [CNTBITS-1:0] CNT_TOP = CNTBITS'(cnt_max(CNTBITS));
    localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

    // x0 has no counter: index 0 is simply absent from the array
    logic [CNTBITS-1:0] cnt [1:NREGS-1];
    logic [NREGS-1:1]   inc_hit, dec_hit, ovf_hit, unf_hit;

    always_comb begin
        busy_mask = '0;
        inc_hit   = '0;
        dec_hit   = '0;
        ovf_hit   = '0;
        unf_hit   = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc_hit[i] = inc && (inc_idx == REGNOBITS'(i));
            dec_hit[i] = dec && (dec_idx == REGNOBITS'(i));
            ovf_hit[i] = inc_hit[i] && !dec_hit[i] && (cnt[i] == CNT_TOP);
            unf_hit[i] = dec_hit[i] && !inc_hit[i] && (cnt[i] == '0);
            // eff = cnt - wb_hit is nonzero exactly when cnt exceeds the WB hit
            busy_mask[i] = (cnt[i] != '0) && !(dec_hit[i] && (cnt[i] == CNT_ONE));
        end
    end

    assign overflow  = |ovf_hit;
    assign underflow = |unf_hit;

    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (inc_hit[i] && !dec_hit[i] && !ovf_hit[i]) begin
                cnt[i] <= cnt[i] + 1'b1;
            end else if (dec_hit[i] && !inc_hit[i] && !unf_hit[i]) begin
                cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// DE-stage interlock: RAW stall via register scoreboard, control-flow serialization.
module hazard_ctrl #(
    parameter int NREGS     = hazard_pkg::NREGS,
    parameter int REGNOBITS = hazard_pkg::REGNOBITS,
    parameter int CNTBITS   = hazard_pkg::CNTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    input  logic [REGNOBITS-1:0] de_rs1,
    input  logic [REGNOBITS-1:0] de_rs2,
    input  logic                 de_rs1_used,
    input  logic                 de_rs2_used,
    input  logic [REGNOBITS-1:0] de_rd,
    input  logic                 de_wr_reg,
    input  logic                 de_is_ctrl,
    input  logic                 agex_br_valid,
    input  logic                 agex_br_redirect,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    output logic                 stall_de,
    output logic                 bubble_de,
    output logic                 flush_fe,
    output logic [NREGS-1:0]     busy_mask,
    output logic                 sb_err
);
    import hazard_pkg::*;

    hz_state_t state, state_nxt;
    logic      hazard, issue, sb_inc, sb_dec, sb_ovf, sb_unf;

    assign sb_inc = issue && de_wr_reg && (de_rd != '0);
    assign sb_dec = wb_wr_reg && (wb_wregno != '0);

    sb_counter_array #(
        .NREGS     (NREGS),
        .REGNOBITS (REGNOBITS),
        .CNTBITS   (CNTBITS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .inc       (sb_inc),
        .inc_idx   (de_rd),
        .dec       (sb_dec),
        .dec_idx   (wb_wregno),
        .busy_mask (busy_mask),
        .overflow  (sb_ovf),
        .underflow (sb_unf)
    );

    // busy_mask already folds in the WB bypass, and bit 0 is never set
    assign hazard = de_valid && ((de_rs1_used && busy_mask[de_rs1]) ||
                                 (de_rs2_used && busy_mask[de_rs2]));

    always_comb begin
        state_nxt = state;
        stall_de  = 1'b0;
        bubble_de = 1'b0;
        flush_fe  = 1'b0;
        issue     = 1'b0;
        case (state)
            HZ_RUN: begin
                stall_de  = hazard;
                bubble_de = hazard;
                issue     = de_valid && !hazard;
                if (issue && de_is_ctrl) begin
                    state_nxt = HZ_CTRL_WAIT;
                end
            end
            HZ_CTRL_WAIT: begin
                // fall-through instruction in DE is held until AGEX resolves
                stall_de  = 1'b1;
                bubble_de = 1'b1;
                if (agex_br_valid) begin
                    flush_fe  = agex_br_redirect;
                    state_nxt = HZ_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HZ_RUN;
            sb_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sb_ovf || sb_unf) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then constrained-random traffic.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid, de_rs1_used, de_rs2_used, de_wr_reg, de_is_ctrl;
    logic [4:0]  de_rs1, de_rs2, de_rd, wb_wregno;
    logic        agex_br_valid, agex_br_redirect, wb_wr_reg;
    logic        stall_de, bubble_de, flush_fe, sb_err;
    logic [31:0] busy_mask;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd(de_rd), .de_wr_reg(de_wr_reg), .de_is_ctrl(de_is_ctrl),
        .agex_br_valid(agex_br_valid), .agex_br_redirect(agex_br_redirect),
        .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno),
        .stall_de(stall_de), .bubble_de(bubble_de), .flush_fe(flush_fe),
        .busy_mask(busy_mask), .sb_err(sb_err)
    );

    typedef struct packed {
        logic       rst;
        logic       dv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ctrl;
        logic       brv;
        logic       redir;
        logic       wb;
        logic [4:0] wbno;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic        err;
        logic [31:0] busy;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pending writes per register, a "waiting on branch" flag, sticky error
    int m_cnt[32];
    bit m_wait;
    bit m_err;

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%s: got %h, expected %h", name, tag, act, req);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s, input string tag, output bit issued);
        exp_t        e;
        logic [31:0] busy;
        bit          haz;
        int          delta;
        reset = s.rst;            de_valid = s.dv;
        de_rs1 = s.rs1;           de_rs2 = s.rs2;
        de_rs1_used = s.u1;       de_rs2_used = s.u2;
        de_rd = s.rd;             de_wr_reg = s.wr;
        de_is_ctrl = s.ctrl;      agex_br_valid = s.brv;
        agex_br_redirect = s.redir;
        wb_wr_reg = s.wb;         wb_wregno = s.wbno;

        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (m_cnt[r] - ((s.wb && s.wbno == r) ? 1 : 0)) > 0;
        end
        haz      = s.dv && ((s.u1 && busy[s.rs1]) || (s.u2 && busy[s.rs2]));
        e.stall  = m_wait || haz;
        e.bubble = m_wait || haz;
        e.flush  = m_wait && s.brv && s.redir;
        e.err    = m_err;
        e.busy   = busy;
        e.tag    = tag;
        exp_q.push_back(e);

        issued = !m_wait && s.dv && !haz;
        if (s.rst) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_wait = 0;
            m_err  = 0;
            issued = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                delta = ((issued && s.wr && s.rd == r) ? 1 : 0) -
                        ((s.wb && s.wbno == r) ? 1 : 0);
                if (delta > 0) begin
                    if (m_cnt[r] == CNT_MAX) m_err = 1; else m_cnt[r]++;
                end else if (delta < 0) begin
                    if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
                end
            end
            m_wait = m_wait ? !s.brv : (issued && s.ctrl);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output vector; compare mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_de",  e.tag, 32'(stall_de),  32'(e.stall));
            chk("bubble_de", e.tag, 32'(bubble_de), 32'(e.bubble));
            chk("flush_fe",  e.tag, 32'(flush_fe),  32'(e.flush));
            chk("sb_err",    e.tag, 32'(sb_err),    32'(e.err));
            chk("busy_mask", e.tag, busy_mask,      e.busy);
        end
    end

    typedef struct { int rd; int age; } flight_t;

    initial begin
        stim_t   s, c;
        bit      iss;
        flight_t fl[$];
        flight_t f;

        s = nop();
        s.rst = 1;
        reset = 1;
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
        de_rd = 0; de_wr_reg = 0; de_is_ctrl = 0; agex_br_valid = 0;
        agex_br_redirect = 0; wb_wr_reg = 0; wb_wregno = 0;
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_wait = 0;
        m_err  = 0;
        repeat (2) @(posedge clk);
        #1;

        apply(nop(), "reset_state", iss);
        apply(nop(), "reset_state2", iss);

        // RAW on x5: two bubbles, released by the WB bypass
        s = nop(); s.dv = 1; s.wr = 1; s.rd = 5;
        apply(s, "raw_prod", iss);
        c = nop(); c.dv = 1; c.u1 = 1; c.rs1 = 5; c.wr = 1; c.rd = 6;
        apply(c, "raw_stall1", iss);
        apply(c, "raw_stall2", iss);
        c.wb = 1; c.wbno = 5;
        apply(c, "raw_release", iss);
        apply(nop(), "raw_after", iss);
        apply(nop(), "raw_after2", iss);
        s = nop(); s.wb = 1; s.wbno = 6;
        apply(s, "raw_wb6", iss);

        // x0 writes are never tracked
        s = nop(); s.dv = 1; s.wr = 1; s.rd = 0;
        apply(s, "x0_write", iss);
        apply(s, "x0_write2", iss);
        c = nop(); c.dv = 1; c.u1 = 1; c.u2 = 1;
        apply(c, "x0_read", iss);

        // Branch with and without redirect
        for (int k = 0; k < 2; k++) begin
            s = nop(); s.dv = 1; s.ctrl = 1;
            apply(s, "br_issue", iss);
            c = nop(); c.dv = 1; c.wr = 1; c.rd = 8;
            apply(c, "br_wait", iss);
            c.brv = 1; c.redir = (k == 0);
            apply(c, "br_resolve", iss);
            c.brv = 0; c.redir = 0;
            if (k == 0) apply(nop(), "br_after", iss);
            else        apply(c, "br_fallthru", iss);
        end

        // Same-cycle issue and retire of x7 leaves one pending write
        s = nop(); s.dv = 1; s.wr = 1; s.rd = 7;
        apply(s, "x7_first", iss);
        apply(nop(), "x7_gap", iss);
        apply(nop(), "x7_gap2", iss);
        s.wb = 1; s.wbno = 7;
        apply(s, "x7_same", iss);
        c = nop(); c.dv = 1; c.u2 = 1; c.rs2 = 7;
        apply(c, "x7_still_busy", iss);
        c.wb = 1; c.wbno = 7;
        apply(c, "x7_retire", iss);

        // Overflow on x3, then underflow on x9
        s = nop(); s.dv = 1; s.wr = 1; s.rd = 3;
        for (int k = 0; k < 4; k++) apply(s, "x3_writer", iss);
        apply(nop(), "x3_ovf", iss);
        s = nop(); s.wb = 1; s.wbno = 9;
        apply(s, "x9_unf", iss);
        c = nop(); c.dv = 1; c.u1 = 1; c.rs1 = 9;
        apply(c, "x9_idle", iss);
        s = nop(); s.wb = 1; s.wbno = 3;
        for (int k = 0; k < 3; k++) apply(s, "x3_drain", iss);
        apply(nop(), "x3_empty", iss);

        // Reset while waiting on a branch with two writes to x4 in flight
        s = nop(); s.rst = 1;
        apply(s, "rst_clean", iss);
        s = nop(); s.dv = 1; s.wr = 1; s.rd = 4;
        apply(s, "x4_w1", iss);
        apply(s, "x4_w2", iss);
        s = nop(); s.dv = 1; s.ctrl = 1;
        apply(s, "rst_br", iss);
        apply(nop(), "rst_wait", iss);
        s = nop(); s.rst = 1; s.wb = 1; s.wbno = 4; s.dv = 1;
        apply(s, "rst_in_wait", iss);
        apply(nop(), "post_reset", iss);

        // Random pipeline traffic with in-order WB at least 3 cycles after issue
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < fl.size(); k++) fl[k].age++;
            s = nop();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.dv   = ($urandom_range(0, 9) < 8);
            s.rs1  = 5'($urandom_range(0, 7));
            s.rs2  = 5'($urandom_range(0, 7));
            s.u1   = 1'($urandom);
            s.u2   = 1'($urandom);
            s.rd   = 5'($urandom_range(0, 7));
            s.wr   = ($urandom_range(0, 9) < 6) && (m_cnt[s.rd] < CNT_MAX);
            s.ctrl = ($urandom_range(0, 7) == 0);
            s.brv  = m_wait ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            s.redir = 1'($urandom);
            if (fl.size() > 0 && fl[0].age >= 3 && $urandom_range(0, 3) != 0) begin
                f = fl.pop_front();
                s.wb   = 1;
                s.wbno = 5'(f.rd);
            end
            apply(s, "random", iss);
            if (s.rst) begin
                fl.delete();
            end else if (iss && s.wr) begin
                f.rd  = int'(s.rd);
                f.age = 0;
                fl.push_back(f);
            end
        end

        apply(nop(), "final", iss);
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
